ballot_gate: RTL and testbench

- Front-end ballot admission stage that sits directly upstream of the vote tally / winner logic.
- Turns the raw voter_id / candidate_number / vote_cast inputs into exactly one validated, handshaked vote per voter.
- Rejects duplicate voters, out-of-range IDs or candidates, and votes cast while the election is closed.
- Keeps a per-voter "has voted" record and a count of accepted votes.

---
 rtl/evm_pkg.sv | 21 ++
 rtl/cast_edge_detect.sv | 19 +
 rtl/ballot_gate.sv | 142 ++++++++++++++
 tb/tb_ballot_gate.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared election constants: reject reasons, admission FSM encoding and default roll sizes.
package evm_pkg;

  localparam int DEF_NUM_VOTERS     = 16;
  localparam int DEF_ID_W           = 4;
  localparam int DEF_NUM_CANDIDATES = 4;
  localparam int DEF_CAND_W         = 4;

  localparam logic [1:0] REJ_CLOSED    = 2'd0;
  localparam logic [1:0] REJ_BAD_VOTER = 2'd1;
  localparam logic [1:0] REJ_BAD_CAND  = 2'd2;
  localparam logic [1:0] REJ_DUP       = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ISSUE = 2'd2,
    S_HOLD  = 2'd3
  } gate_state_t;

endpackage

// File: rtl/cast_edge_detect.sv
// Registered rising-edge detector for button levels; the history flop resets high
// so a button already held at reset release does not register as a press.
module cast_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/ballot_gate.sv
// Ballot admission: one validated, handshaked vote per voter, with reject reasons
// and a running count of completed handshakes.
//
//   state   | meaning
//   S_IDLE  | waiting for a cast press
//   S_CHECK | captured cast being validated
//   S_ISSUE | vote presented downstream, waiting for vote_ready
//   S_HOLD  | outcome done, waiting for the button to be released
module ballot_gate
  import evm_pkg::*;
#(
  parameter int NUM_VOTERS     = DEF_NUM_VOTERS,
  parameter int ID_W           = DEF_ID_W,
  parameter int NUM_CANDIDATES = DEF_NUM_CANDIDATES,
  parameter int CAND_W         = DEF_CAND_W,
  parameter int CNT_W          = $clog2(NUM_VOTERS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   voter_id,
  input  logic [CAND_W-1:0] candidate_number,
  input  logic              vote_cast,
  input  logic              election_open,
  output logic              vote_valid,
  input  logic              vote_ready,
  output logic [ID_W-1:0]   vote_voter_id,
  output logic [CAND_W-1:0] vote_candidate,
  output logic              reject,
  output logic [1:0]        reject_code,
  output logic [CNT_W-1:0]  votes_accepted,
  output logic              all_voted
);

  localparam logic [ID_W:0]    ID_LIMIT   = (ID_W+1)'(NUM_VOTERS);
  localparam logic [CAND_W:0]  CAND_LIMIT = (CAND_W+1)'(NUM_CANDIDATES);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(NUM_VOTERS);

  gate_state_t             state_q, state_d;
  logic [ID_W-1:0]         cap_id_q;
  logic [CAND_W-1:0]       cap_cand_q;
  logic [NUM_VOTERS-1:0]   voted_q;
  logic [CNT_W-1:0]        count_q;
  logic                    all_voted_q;
  logic                    reject_q;
  logic [1:0]              reject_code_q;

  logic                    cast;
  logic                    capture;
  logic                    accept;
  logic                    rej_fire;
  logic [1:0]              rej_code_d;
  logic                    id_bad;
  logic                    cand_bad;

  cast_edge_detect u_cast_edge (
    .clk   (clk),
    .rst   (rst),
    .level (vote_cast),
    .rise  (cast)
  );

  assign id_bad   = {1'b0, cap_id_q} >= ID_LIMIT;
  assign cand_bad = {1'b0, cap_cand_q} >= CAND_LIMIT;

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    accept     = 1'b0;
    rej_fire   = 1'b0;
    rej_code_d = REJ_CLOSED;
    case (state_q)
      S_IDLE: begin
        if (cast) begin
          capture = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Rule order matters: the first failing rule names the reason.
        if (!election_open) begin
          rej_fire   = 1'b1;
          rej_code_d = REJ_CLOSED;
        end else if (id_bad) begin
          rej_fire   = 1'b1;
          rej_code_d = REJ_BAD_VOTER;
        end else if (cand_bad) begin
          rej_fire   = 1'b1;
          rej_code_d = REJ_BAD_CAND;
        end else if (voted_q[cap_id_q]) begin
          rej_fire   = 1'b1;
          rej_code_d = REJ_DUP;
        end
        state_d = rej_fire ? S_HOLD : S_ISSUE;
      end
      S_ISSUE: begin
        if (vote_ready) begin
          accept  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!vote_cast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cap_id_q      <= '0;
      cap_cand_q    <= '0;
      voted_q       <= '0;
      count_q       <= '0;
      all_voted_q   <= 1'b0;
      reject_q      <= 1'b0;
      reject_code_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      reject_q      <= rej_fire;
      reject_code_q <= rej_code_d;
      if (capture) begin
        cap_id_q   <= voter_id;
        cap_cand_q <= candidate_number;
      end
      if (accept) begin
        voted_q[cap_id_q] <= 1'b1;
        count_q           <= count_q + CNT_W'(1);
        all_voted_q       <= (count_q + CNT_W'(1)) == CNT_FULL;
      end
    end
  end

  assign vote_valid     = (state_q == S_ISSUE);
  assign vote_voter_id  = cap_id_q;
  assign vote_candidate = cap_cand_q;
  assign reject         = reject_q;
  assign reject_code    = reject_code_q;
  assign votes_accepted = count_q;
  assign all_voted      = all_voted_q;

endmodule

// File: tb/tb_ballot_gate.sv
// Directed and randomized bench for ballot_gate against a roll-level reference model.
module tb_ballot_gate;

  localparam int NV = 16;
  localparam int NC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] voter_id;
  logic [3:0] candidate_number;
  logic       vote_cast;
  logic       election_open;
  logic       vote_valid;
  logic       vote_ready;
  logic [3:0] vote_voter_id;
  logic [3:0] vote_candidate;
  logic       reject;
  logic [1:0] reject_code;
  logic [4:0] votes_accepted;
  logic       all_voted;

  int errors = 0;
  int checks = 0;

  bit model_voted [NV];
  int model_count;

  ballot_gate dut (
    .clk              (clk),
    .rst              (rst),
    .voter_id         (voter_id),
    .candidate_number (candidate_number),
    .vote_cast        (vote_cast),
    .election_open    (election_open),
    .vote_valid       (vote_valid),
    .vote_ready       (vote_ready),
    .vote_voter_id    (vote_voter_id),
    .vote_candidate   (vote_candidate),
    .reject           (reject),
    .reject_code      (reject_code),
    .votes_accepted   (votes_accepted),
    .all_voted        (all_voted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void model_clear();
    foreach (model_voted[i]) model_voted[i] = 1'b0;
    model_count = 0;
  endfunction

  // -1 means the cast is admitted, otherwise the refusal reason.
  function automatic int model_outcome(input bit open, input int id, input int cand);
    if (!open)              return 0;
    if (id >= NV)           return 1;
    if (cand >= NC)         return 2;
    if (model_voted[id])    return 3;
    return -1;
  endfunction

  task automatic do_reset(input bit cast_level);
    rst = 1'b1;
    vote_cast = cast_level;
    vote_ready = 1'b0;
    cycle();
    cycle();
    check("rst_valid", 32'(vote_valid), 0);
    check("rst_reject", 32'(reject), 0);
    check("rst_code", 32'(reject_code), 0);
    check("rst_count", 32'(votes_accepted), 0);
    check("rst_all", 32'(all_voted), 0);
    check("rst_id", 32'(vote_voter_id), 0);
    check("rst_cand", 32'(vote_candidate), 0);
    rst = 1'b0;
    model_clear();
    cycle();
  endtask

  task automatic cast(input int id, input int cand, input bit open, input int lat,
                      input int hold, input bit drop);
    int outcome;
    outcome = model_outcome(open, id, cand);
    voter_id = 4'(id);
    candidate_number = 4'(cand);
    election_open = open;
    vote_cast = 1'b1;
    vote_ready = (lat == 0);
    @(posedge clk);
    #1;
    voter_id = 4'($urandom);
    candidate_number = 4'($urandom);
    @(negedge clk);
    check("pre_valid", 32'(vote_valid), 0);
    check("pre_reject", 32'(reject), 0);
    cycle();
    if (outcome >= 0) begin
      check("rej_pulse", 32'(reject), 1);
      check("rej_code", 32'(reject_code), 32'(outcome));
      check("rej_valid", 32'(vote_valid), 0);
      cycle();
      check("rej_end", 32'(reject), 0);
      check("rej_count", 32'(votes_accepted), 32'(model_count));
    end else begin
      check("valid_rise", 32'(vote_valid), 1);
      check("valid_id", 32'(vote_voter_id), 32'(id));
      check("valid_cand", 32'(vote_candidate), 32'(cand));
      check("valid_noreject", 32'(reject), 0);
      if (drop) begin
        election_open = 1'b0;
        vote_cast = 1'b0;
      end
      for (int i = 0; i < lat; i++) begin
        cycle();
        check("stall_valid", 32'(vote_valid), 1);
        check("stall_id", 32'(vote_voter_id), 32'(id));
        check("stall_cand", 32'(vote_candidate), 32'(cand));
        check("stall_count", 32'(votes_accepted), 32'(model_count));
      end
      vote_ready = 1'b1;
      cycle();
      model_voted[id] = 1'b1;
      model_count++;
      check("hs_valid_drop", 32'(vote_valid), 0);
      check("hs_count", 32'(votes_accepted), 32'(model_count));
      check("hs_all", 32'(all_voted), 32'(model_count == NV));
    end
    vote_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cycle();
      check("hold_valid", 32'(vote_valid), 0);
      check("hold_reject", 32'(reject), 0);
    end
    vote_cast = 1'b0;
    election_open = open;
    cycle();
    cycle();
    check("idle_count", 32'(votes_accepted), 32'(model_count));
  endtask

  initial begin
    int order [15];
    rst = 1'b1;
    voter_id = '0;
    candidate_number = '0;
    vote_cast = 1'b0;
    election_open = 1'b1;
    vote_ready = 1'b1;
    model_clear();
    @(negedge clk);

    do_reset(1'b0);

    cast(0, 0, 1, 0, 0, 0);
    cast(1, 1, 1, 0, 0, 0);
    cast(2, 1, 1, 0, 0, 0);
    cast(3, 2, 1, 0, 0, 0);
    cast(4, 2, 1, 0, 0, 0);
    check("five_count", 32'(votes_accepted), 5);

    cast(1, 3, 1, 0, 0, 0);
    cast(5, 7, 1, 0, 0, 0);
    cast(6, 0, 0, 0, 0, 0);
    cast(6, 0, 1, 0, 0, 0);
    cast(9, 1, 1, 3, 0, 0);
    cast(7, 2, 1, 0, 17, 0);
    cast(10, 3, 1, 2, 0, 1);
    check("directed_count", 32'(votes_accepted), 9);

    do_reset(1'b1);
    vote_cast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("held_valid", 32'(vote_valid), 0);
      check("held_reject", 32'(reject), 0);
    end
    vote_cast = 1'b0;
    cycle();
    cast(11, 0, 1, 0, 0, 0);

    for (int n = 0; n < 30; n++)
      cast($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 9) != 0,
           $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    do_reset(1'b0);
    voter_id = 4'd8;
    candidate_number = 4'd1;
    election_open = 1'b1;
    vote_cast = 1'b1;
    vote_ready = 1'b0;
    cycle();
    cycle();
    check("abort_valid_pre", 32'(vote_valid), 1);
    rst = 1'b1;
    vote_ready = 1'b1;
    cycle();
    check("abort_valid", 32'(vote_valid), 0);
    check("abort_count", 32'(votes_accepted), 0);
    rst = 1'b0;
    vote_ready = 1'b0;
    vote_cast = 1'b0;
    model_clear();
    cycle();
    cycle();
    check("abort_count_after", 32'(votes_accepted), 0);

    cast(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) order[i] = i + 1;
    for (int i = 14; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 15; i++) begin
      check("not_all_yet", 32'(all_voted), 0);
      cast(order[i], $urandom_range(0, 3), 1, $urandom_range(0, 3), 0, 0);
    end
    check("full_count", 32'(votes_accepted), 16);
    check("full_all", 32'(all_voted), 1);
    cast(order[3], 0, 1, 0, 0, 0);
    check("full_all_after_dup", 32'(all_voted), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
